sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO. Successor to the basic sync FIFO.
//  Adds: any depth >= 2 (not only powers of two), first-word-fall-through (FWFT) mode,
//  programmable almost-full/almost-empty, an occupancy output, write-while-full when a
//  read is accepted in the same cycle, sticky overflow/underflow, and a synchronous flush.
//  Used as the general-purpose buffer between same-clock streaming stages.
// PARAMETERS
//  WIDTH      16        data width in bits (>=1)
//  DEPTH      8         number of entries (>=2, any integer)
//  FWFT       0         0 = standard registered read; 1 = first-word-fall-through
//  AF_THRESH  DEPTH-2   almost_full asserts when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2         almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1              clock, rising edge
//  reset         in   1              reset, asynchronous, active-high
//  clr           in   1              synchronous flush
//  w_enb         in   1              write request
//  din           in   WIDTH          write data
//  r_enb         in   1              read request (pop)
//  dout          out  WIDTH          read data
//  valid         out  1              dout holds valid data (see BEHAVIOUR)
//  empty         out  1              count == 0
//  full          out  1              count == DEPTH
//  almost_empty  out  1              count <= AE_THRESH
//  almost_full   out  1              count >= AF_THRESH
//  count         out  CW             occupancy, CW = $clog2(DEPTH+1)
//  overflow      out  1              sticky: write request dropped
//  underflow     out  1              sticky: read request on empty
// BEHAVIOUR
//  - Reset (async): wptr = rptr = count = 0; dout = 0; valid = 0; overflow = underflow = 0.
//    empty = 1, almost_empty = 1, full = 0, almost_full = 0. Memory is not reset.
//  - rd_ok = r_enb & !empty.  wr_ok = w_enb & (!full | rd_ok).
//  - At full with w_enb & r_enb, both operations are accepted and count is held.
//  - At empty with w_enb & r_enb, only the write is accepted. Underflow is set.
//    The new word is not bypassed to dout.
//  - Pointers wrap explicitly: DEPTH-1 -> 0. No modulo on power-of-two assumptions.
//  - count: +1 on wr_ok only, -1 on rd_ok only, held otherwise. Never exceeds DEPTH; never goes below 0.
//  - Flags are decoded from the count register. They change on the edge after the causing operation.
//  - overflow is set on w_enb & !wr_ok. underflow is set on r_enb & empty.
//    Both stay set until reset or clr.
//  - FWFT=0: on rd_ok, dout <= mem[rptr] at the edge and valid = 1 for the following cycle.
//    valid = 0 otherwise. dout holds its last value when no read occurs. Read latency is 1 cycle.
//  - FWFT=1: dout = mem[rptr] combinationally while !empty, and 0 when empty.
//    valid = !empty. r_enb acknowledges the shown word, which is consumed at that edge.
//    A written word is visible on dout 1 cycle after the write into an empty FIFO.
//  - clr (sync): takes priority over w_enb and r_enb in the same cycle.
//    Clears pointers, count, valid, overflow and underflow. dout is held (FWFT=0) or forced to 0 (FWFT=1).
//    Memory is untouched.
//  - Reset asserted mid-operation aborts the operation immediately. No partial writes are observable.
//  - Elaboration error if AF_THRESH or AE_THRESH is out of range, or if DEPTH < 2.
// STRUCTURE
//  - fifo_pkg holds:
//    - function clog2_min1(n), which returns at least 1;
//    - localparams FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
//  - Sub-module fifo_mem_2p #(WIDTH, DEPTH):
//    - register array, 1 sync write port, 1 async read port;
//    - no reset.
//  - Top holds pointers, count, flags, sticky bits, and the FWFT/standard output mux.
// TESTING
//  1 Reset with DEPTH=8, FWFT=0 -> empty=1, almost_empty=1, count=0, dout=0, valid=0.
//  2 Write 0x0001..0x0008 -> full=1, count=8, almost_full asserted at count=6.
//    A ninth write of 0xDEAD sets overflow=1 and count stays 8.
//  3 Full FIFO, w_enb=r_enb=1 with din=0x0009 -> dout=0x0001, count stays 8.
//    Draining then yields 0x0002..0x0009 in order.
//  4 DEPTH=5: 12 writes interleaved with reads -> data in order across a pointer wrap at index 4.
//    count tracks a reference model every cycle.
//  5 FWFT=1: write 0x00AA into empty -> next cycle valid=1, dout=0x00AA.
//    r_enb then gives empty=1 and dout=0. An extra r_enb sets underflow=1.
//  6 clr with w_enb=1 at count=3 -> count=0, empty=1, overflow/underflow cleared, and the write is dropped.
//    Async reset mid-burst -> reset values are immediate.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers and mode constants for the sync_fifo_flags family.
// Pulled into the FIFO top and memory files with a wildcard import.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width for an n-entry array; a 1-entry or 2-entry array still needs one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Unreset register array: one synchronous write port, one asynchronous read port.
// The address width follows the entry count, so DEPTH does not have to be a power of two.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of any depth >= 2, with a standard or FWFT read port, programmable
// almost flags, an occupancy count, sticky overflow/underflow and a synchronous flush.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             w_enb,
    input  logic [WIDTH-1:0] din,
    input  logic             r_enb,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = clog2_min1(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH must lie in 0..DEPTH-1");
    end

    logic [AW-1:0]    wptr_q, rptr_q, wptr_nxt, rptr_nxt;
    logic [CW-1:0]    count_q;
    logic             overflow_q, underflow_q;
    logic             rd_ok, wr_ok;
    logic [WIDTH-1:0] rd_data;

    // Handshake: w_enb/r_enb are requests; a request is taken only when wr_ok/rd_ok is
    // high at the rising edge. A refused write sets overflow, a read on empty sets underflow,
    // and a write into a full FIFO is taken when a read is taken in the same cycle.
    assign rd_ok = r_enb & ~empty;
    assign wr_ok = w_enb & (~full | rd_ok);

    assign wptr_nxt = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    assign rptr_nxt = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok & ~clr),
        .waddr (wptr_q),
        .wdata (din),
        .raddr (rptr_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wptr_q <= wptr_nxt;
            if (rd_ok) rptr_q <= rptr_nxt;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (w_enb & ~wr_ok) overflow_q  <= 1'b1;
            if (r_enb & empty)  underflow_q <= 1'b1;
        end
    end

    // All flags come straight from the count register, so they move one edge after the cause.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown while data is present; r_enb consumes it at the edge.
        assign dout  = empty ? '0 : rd_data;
        assign valid = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] dout_q;
        logic             valid_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else if (clr) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) dout_q <= rd_data;
            end
        end

        assign dout  = dout_q;
        assign valid = valid_q;
    end

endmodule
